// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/subtract with valid/ready handshake.
// Optional signed saturation is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage registers: operands (b already inverted for subtract),
    // partial result, chunk carry-out and a valid bit per stage.
    logic             vld [STAGES];
    logic [WIDTH-1:0] ra  [STAGES];
    logic [WIDTH-1:0] rb  [STAGES];
    logic [WIDTH-1:0] rs  [STAGES];
    logic             rc  [STAGES];
    logic             ro;
`ifdef PIPELINED_ADDER_SAT_EN
    logic             rsat [STAGES];
    logic             si_sat [STAGES];
`endif

    logic [WIDTH-1:0] si_a [STAGES];
    logic [WIDTH-1:0] si_b [STAGES];
    logic [WIDTH-1:0] si_s [STAGES];
    logic             si_c [STAGES];
    logic [WIDTH-1:0] n_s  [STAGES];
    logic             n_c  [STAGES];
    logic [CW:0]      chunk;
    logic             c_msb_in;
    logic             n_o;
    logic [WIDTH-1:0] n_y;
    logic             stall;

    assign stall     = vld[L] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld[L];
    assign y         = rs[L];
    assign carry     = rc[L];
    assign overflow  = ro;

    // Per-stage chunk adders; stage k consumes chunk k and the carry of k-1.
    always_comb begin
        si_a[0] = a;
        si_b[0] = b ^ {WIDTH{sub}};
        si_s[0] = '0;
        si_c[0] = sub;
`ifdef PIPELINED_ADDER_SAT_EN
        si_sat[0] = sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            si_a[k] = ra[k-1];
            si_b[k] = rb[k-1];
            si_s[k] = rs[k-1];
            si_c[k] = rc[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
            si_sat[k] = rsat[k-1];
`endif
        end
        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, si_a[k][k*CW +: CW]}
                  + {1'b0, si_b[k][k*CW +: CW]}
                  + {{CW{1'b0}}, si_c[k]};
            n_s[k] = si_s[k];
            n_s[k][k*CW +: CW] = chunk[CW-1:0];
            n_c[k] = chunk[CW];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        c_msb_in = n_s[L][WIDTH-1] ^ si_a[L][WIDTH-1] ^ si_b[L][WIDTH-1];
        n_o = c_msb_in ^ n_c[L];
        n_y = n_s[L];
`ifdef PIPELINED_ADDER_SAT_EN
        if (si_sat[L] && n_o)
            n_y = si_a[L][WIDTH-1] ? SMIN : SMAX;
`endif
    end

    // Whole pipeline advances together unless the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld[k] <= 1'b0;
                ra[k]  <= '0;
                rb[k]  <= '0;
                rs[k]  <= '0;
                rc[k]  <= 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
                rsat[k] <= 1'b0;
`endif
            end
            ro <= 1'b0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld[k] <= vld[k-1];
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= si_a[k];
                rb[k] <= si_b[k];
                rs[k] <= (k == L) ? n_y : n_s[k];
                rc[k] <= n_c[k];
`ifdef PIPELINED_ADDER_SAT_EN
                rsat[k] <= si_sat[k];
`endif
            end
            ro <= n_o;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: vector table plus scoreboard for pipelined_adder.
// Build with PIPELINED_ADDER_SAT_EN defined to also cover saturation.
module tb_pipelined_adder;

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        o;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] ey;
        logic        ec;
        logic        eo;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        carry;
    logic        overflow;

    res_t sb[$];
    vec_t tbl[9];
    int   n_chk;
    int   n_err;
    int   cyc;
    int   pops;
    int   first_pop;
    int   last_pop;
    int   lat;
    int   guard;
    logic [31:0] held;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
`ifdef PIPELINED_ADDER_SAT_EN
        .sat      (sat_i),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t model(logic [31:0] ma, logic [31:0] mb,
                                   logic ms, logic msat);
        res_t        r;
        logic [31:0] bb;
        logic [32:0] t;
        bb  = ms ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bb} + {32'd0, ms};
        r.y = t[31:0];
        r.c = t[32];
        r.o = (ma[31] == bb[31]) && (t[31] != ma[31]);
        if (msat && r.o)
            r.y = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: score output and input transfers, then advance to negedge.
    task automatic tick();
        res_t e;
        if (out_valid && out_ready) begin
            if (pops == 0)
                first_pop = cyc;
            last_pop = cyc;
            pops++;
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_output: got y=%h expected none", y);
            end else begin
                e = sb.pop_front();
                chk("sb_y", y, e.y);
                chk("sb_carry", {31'd0, carry}, {31'd0, e.c});
                chk("sb_ovf", {31'd0, overflow}, {31'd0, e.o});
            end
        end
        if (in_valid && in_ready)
            sb.push_back(model(a, b, sub, sat_i));
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(int limit);
        guard = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && guard < limit) begin
            tick();
            guard++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[7] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[8] = '{32'h1234_5678, 32'h1234_5679, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

        n_chk = 0;
        n_err = 0;
        cyc = 0;
        pops = 0;
        first_pop = 0;
        last_pop = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        sub = 1'b0;
        sat_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single ops from the table: latency and exact results.
        for (int i = 0; i < 9; i++) begin
            a = tbl[i].a;
            b = tbl[i].b;
            sub = tbl[i].sub;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("latency_%0d", i), lat, 4);
            chk($sformatf("tbl_y_%0d", i), y, tbl[i].ey);
            chk($sformatf("tbl_c_%0d", i), {31'd0, carry}, {31'd0, tbl[i].ec});
            chk($sformatf("tbl_o_%0d", i), {31'd0, overflow}, {31'd0, tbl[i].eo});
            tick();
        end

        // Back-to-back stream of 10 ops with out_ready held high.
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        drain(40);
        chk("stream_count", pops, 10);
        chk("stream_span", last_pop - first_pop, 9);

        // Backpressure: fill with out_ready low, then hold.
        pops = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", sb.size(), 4);
        held = y;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_y_held", y, held);
            tick();
        end
        in_valid = 1'b0;
        drain(40);
        chk("bp_count", pops, 4);

        // Asynchronous reset with ops in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            sub = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_y", y, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
            tick();
        end
        pops = 0;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        drain(20);
        chk("post_rst_op", pops, 1);

`ifdef PIPELINED_ADDER_SAT_EN
        // Saturation clamps positive and negative overflow.
        sat_i = 1'b1;
        a = 32'h7FFF_FFFF;
        b = 32'h0000_0001;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("sat_pos_y", y, 32'h7FFF_FFFF);
        chk("sat_pos_o", {31'd0, overflow}, 32'd1);
        tick();
        a = 32'h8000_0000;
        b = 32'h0000_0001;
        sub = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        chk("sat_neg_y", y, 32'h8000_0000);
        chk("sat_neg_c", {31'd0, carry}, 32'd1);
        tick();
        sat_i = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
